control_fsm: RTL and testbench
==============================

# control_fsm

Main control unit of the multi-cycle RV32I datapath. It is a Moore state machine that decodes the 7-bit opcode of the instruction held in the instruction register. Each cycle it drives the datapath enables and mux selects. The ALU decoder and the PCWrite gate (`Branch & Zero | PCUpdate`) are separate blocks outside this one.

## Interface
Parameters: none.
- `i_Clk` in 1: single clock; all state changes on its rising edge.
- `i_Reset` in 1: synchronous, active-high reset; forces state FETCH.
- `i_OpCode` in 7: instruction opcode bits [6:0]. Codes: lw=0000011, sw=0100011, R-type=0110011, I-type ALU=0010011, jal=1101111, beq=1100011.
- `o_Branch` out 1: beq in progress; external logic ANDs it with Zero.
- `o_PCUpdate` out 1: unconditional PC write.
- `o_IRWrite` out 1: load instruction register and old-PC register.
- `o_ResultSrc` out 2: 00=ALUOut, 01=Data, 10=ALUResult.
- `o_MemWrite` out 1: memory write enable.
- `o_ALUSrcA` out 2: 00=PC, 01=OldPC, 10=RD1 register A.
- `o_ALUSrcB` out 2: 00=RD2 register B, 01=ImmExt, 10=constant 4.
- `o_RegWrite` out 1: register file write enable.
- `o_ALUOp` out 2: 00=add, 01=subtract for compare, 10=decode funct fields.
- `o_AdrSrc` out 1: memory address select; 0=PC, 1=Result.
- `o_State` out 4: current state encoding.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10. Codes 11–15 are illegal and go to FETCH on the next edge.
- Outputs are purely combinational from state (Moore). Any signal not listed for a state is 0, including all 2-bit fields.
- Outputs per state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- Transitions:
  - FETCH→DECODE.
  - From DECODE: lw or sw→MEMADR; R→EXECUTER; I→EXECUTEI; jal→JAL; beq→BEQ; any other opcode→FETCH (instruction treated as a no-op).
  - From MEMADR: lw→MEMREAD; sw→MEMWRITE; any other→FETCH.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER→ALUWB and EXECUTEI→ALUWB; ALUWB→FETCH.
  - JAL→ALUWB (writes PC+4 to rd).
  - BEQ→FETCH.
- `i_OpCode` is only sampled in DECODE and MEMADR. It must be stable from DECODE until the instruction returns to FETCH.

## Timing
- Reset is synchronous: if `i_Reset`=1 at a rising edge, the state becomes FETCH. This overrides the transition logic, including mid-instruction.
- Outputs after reset equal the FETCH outputs.
- Cycles per instruction, counted from FETCH inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3, invalid 2.
- Outputs change only after a rising edge, with combinational delay. No outputs are registered.

## Test plan
- Reset: assert `i_Reset` across one edge → `o_State`=0. IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10, all other outputs 0.
- lw (0000011) → states 0,1,2,3,4,0. MEMWB has RegWrite=1, ResultSrc=01. MEMREAD has AdrSrc=1.
- sw (0100011) → states 0,1,2,5,0. MEMWRITE has MemWrite=1, AdrSrc=1, RegWrite=0.
- R (0110011) → 0,1,6,8,0 with ALUOp=10, ALUSrcB=00. I (0010011) → 0,1,7,8,0 with ALUSrcB=01.
- jal (1101111) → 0,1,9,8,0. JAL state has PCUpdate=1, ALUSrcA=01, ALUSrcB=10. beq (1100011) → 0,1,10,0 with Branch=1, ALUOp=01.
- Invalid opcode 1111111 → 0,1,0. Reset asserted while in MEMREAD → FETCH on the next edge.

Source files
------------

// File: rtl/control_fsm.sv
// Main control unit of the multi-cycle RV32I datapath: a Moore FSM that
// steps through the phases of each instruction and drives enables/mux selects.
module control_fsm (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [6:0] i_OpCode,
  output logic       o_Branch,
  output logic       o_PCUpdate,
  output logic       o_IRWrite,
  output logic [1:0] o_ResultSrc,
  output logic       o_MemWrite,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic       o_RegWrite,
  output logic [1:0] o_ALUOp,
  output logic       o_AdrSrc,
  output logic [3:0] o_State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state;
  state_t state_next;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= FETCH;
    else         state <= state_next;
  end

  // Unknown opcodes retire as a no-op by falling back to FETCH.
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (i_OpCode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        case (i_OpCode)
          OP_LW:   state_next = MEMREAD;
          OP_SW:   state_next = MEMWRITE;
          default: state_next = FETCH;
        endcase
      end
      MEMREAD:  state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      JAL:      state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Moore outputs: decoded from the current state only, zero unless listed.
  always_comb begin
    o_Branch    = 1'b0;
    o_PCUpdate  = 1'b0;
    o_IRWrite   = 1'b0;
    o_ResultSrc = 2'b00;
    o_MemWrite  = 1'b0;
    o_ALUSrcA   = 2'b00;
    o_ALUSrcB   = 2'b00;
    o_RegWrite  = 1'b0;
    o_ALUOp     = 2'b00;
    o_AdrSrc    = 1'b0;
    case (state)
      FETCH: begin
        o_IRWrite   = 1'b1;
        o_ALUSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
        o_PCUpdate  = 1'b1;
      end
      DECODE: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b01;
      end
      MEMADR: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
      end
      MEMREAD: o_AdrSrc = 1'b1;
      MEMWB: begin
        o_ResultSrc = 2'b01;
        o_RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        o_AdrSrc   = 1'b1;
        o_MemWrite = 1'b1;
      end
      EXECUTER: begin
        o_ALUSrcA = 2'b10;
        o_ALUOp   = 2'b10;
      end
      EXECUTEI: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
        o_ALUOp   = 2'b10;
      end
      ALUWB: o_RegWrite = 1'b1;
      JAL: begin
        o_ALUSrcA  = 2'b01;
        o_ALUSrcB  = 2'b10;
        o_PCUpdate = 1'b1;
      end
      BEQ: begin
        o_ALUSrcA = 2'b10;
        o_ALUOp   = 2'b01;
        o_Branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_State = state;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: an opcode-level model predicts the state
// walk of each instruction and the control word expected in every state.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       branch, pc_update, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  logic [13:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  control_fsm dut (
    .i_Clk(clk), .i_Reset(rst), .i_OpCode(opcode),
    .o_Branch(branch), .o_PCUpdate(pc_update), .o_IRWrite(ir_write),
    .o_ResultSrc(result_src), .o_MemWrite(mem_write), .o_ALUSrcA(alu_src_a),
    .o_ALUSrcB(alu_src_b), .o_RegWrite(reg_write), .o_ALUOp(alu_op),
    .o_AdrSrc(adr_src), .o_State(state)
  );

  always #5 clk = ~clk;

  assign ctrl = {branch, pc_update, ir_write, result_src, mem_write,
                 alu_src_a, alu_src_b, reg_write, alu_op, adr_src};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] word(input logic br, input logic pcu, input logic irw,
      input logic [1:0] rs, input logic mw, input logic [1:0] sa, input logic [1:0] sb,
      input logic rw, input logic [1:0] op, input logic adr);
    return {br, pcu, irw, rs, mw, sa, sb, rw, op, adr};
  endfunction

  // Expected control word per state, straight from the per-state table.
  function automatic logic [13:0] exp_ctrl(input int s);
    case (s)
      0:  return word(0, 1, 1, 2'b10, 0, 2'b00, 2'b10, 0, 2'b00, 0);
      1:  return word(0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 0, 2'b00, 0);
      2:  return word(0, 0, 0, 2'b00, 0, 2'b10, 2'b01, 0, 2'b00, 0);
      3:  return word(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 1);
      4:  return word(0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 2'b00, 0);
      5:  return word(0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 1);
      6:  return word(0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 2'b10, 0);
      7:  return word(0, 0, 0, 2'b00, 0, 2'b10, 2'b01, 0, 2'b10, 0);
      8:  return word(0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 0);
      9:  return word(0, 1, 0, 2'b00, 0, 2'b01, 2'b10, 0, 2'b00, 0);
      10: return word(1, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 2'b01, 0);
      default: return 14'd0;
    endcase
  endfunction

  // States visited after FETCH for one instruction, ending back in FETCH.
  function automatic void walk(input logic [6:0] op, output int q[$]);
    q = {};
    case (op)
      7'b0000011: q = {1, 2, 3, 4, 0};
      7'b0100011: q = {1, 2, 5, 0};
      7'b0110011: q = {1, 6, 8, 0};
      7'b0010011: q = {1, 7, 8, 0};
      7'b1101111: q = {1, 9, 8, 0};
      7'b1100011: q = {1, 10, 0};
      default:    q = {1, 0};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int exp);
    check({tag, "_state"}, {28'd0, state}, exp);
    check({tag, "_ctrl"}, {18'd0, ctrl}, {18'd0, exp_ctrl(exp)});
  endtask

  // Runs one instruction from FETCH; reset_at >= 0 asserts reset before that edge.
  task automatic run_instr(input logic [6:0] op, input int reset_at, input string tag);
    int exp_q[$];
    walk(op, exp_q);
    opcode = op;
    check_state({tag, "_fetch"}, 0);
    foreach (exp_q[k]) begin
      if (k == reset_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_state({tag, "_midrst"}, 0);
        return;
      end
      step();
      check_state(tag, exp_q[k]);
    end
  endtask

  initial begin
    logic [6:0] ops[6];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

    rst = 1'b1;
    step();
    step();
    check_state("reset", 0);
    rst = 1'b0;

    run_instr(7'b0000011, -1, "lw");
    run_instr(7'b0100011, -1, "sw");
    run_instr(7'b0110011, -1, "rtype");
    run_instr(7'b0010011, -1, "itype");
    run_instr(7'b1101111, -1, "jal");
    run_instr(7'b1100011, -1, "beq");
    run_instr(7'b1111111, -1, "invalid");
    run_instr(7'b0000011, 3, "lw_rst_memread");

    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      int sel, rat;
      sel = int'($urandom_range(0, 7));
      op  = (sel < 6) ? ops[sel] : 7'($urandom_range(0, 127));
      rat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, rat, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
